// File: rtl/imm32_encoder_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm32_encoder_if : request/result handshake bundle for imm32_encoder
// Revision: 1.0
// ---------------------------------------------------------------------------
interface imm32_encoder_if #(
  parameter int ROT_W = 4
);
  logic              start_valid;
  logic              start_ready;
  logic [31:0]       start_value;
  logic              start_allow_inv;
  logic              result_valid;
  logic              result_ready;
  logic              result_found;
  logic              result_inverted;
  logic [7:0]        result_imm8;
  logic [ROT_W-1:0]  result_rotate;

  modport master (
    output start_valid, start_value, start_allow_inv, result_ready,
    input  start_ready, result_valid, result_found, result_inverted,
           result_imm8, result_rotate
  );

  modport slave (
    input  start_valid, start_value, start_allow_inv, result_ready,
    output start_ready, result_valid, result_found, result_inverted,
           result_imm8, result_rotate
  );
endinterface
`default_nettype wire

// File: rtl/imm32_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// imm32_encoder : searches imm8/rotate (direct, then complement) for a constant
// Revision: 1.0
// ---------------------------------------------------------------------------
module imm32_encoder #(
  parameter int ROT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  imm32_encoder_if.slave    enc_if
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIR  = 2'd1;
  localparam logic [1:0] S_INV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q,     state_d;
  logic [31:0]      value_q,     value_d;
  logic             allow_inv_q, allow_inv_d;
  logic [ROT_W-1:0] r_q,         r_d;
  logic             found_q,     found_d;
  logic             inverted_q,  inverted_d;
  logic [7:0]       imm8_q,      imm8_d;
  logic [ROT_W-1:0] rotate_q,    rotate_d;

  logic [31:0] w_target;
  logic [5:0]  w_shamt;
  logic [31:0] w_rot;
  logic        w_hit;
  logic        w_r_last;

  // ROL by 2*r; a shift by 32 yields 0 so r=0 degenerates to the identity.
  assign w_target = (state_q == S_INV) ? ~value_q : value_q;
  assign w_shamt  = 6'({r_q, 1'b0});
  assign w_rot    = (w_target << w_shamt) | (w_target >> (6'd32 - w_shamt));
  assign w_hit    = ~|w_rot[31:8];
  assign w_r_last = &r_q;

  always_comb begin
    state_d     = state_q;
    value_d     = value_q;
    allow_inv_d = allow_inv_q;
    r_d         = r_q;
    found_d     = found_q;
    inverted_d  = inverted_q;
    imm8_d      = imm8_q;
    rotate_d    = rotate_q;
    case (state_q)
      S_IDLE: begin
        if (enc_if.start_valid) begin
          value_d     = enc_if.start_value;
          allow_inv_d = enc_if.start_allow_inv;
          r_d         = '0;
          state_d     = S_DIR;
        end
      end
      S_DIR, S_INV: begin
        if (w_hit) begin
          found_d    = 1'b1;
          inverted_d = (state_q == S_INV);
          imm8_d     = w_rot[7:0];
          rotate_d   = r_q;
          state_d    = S_DONE;
        end else if (w_r_last) begin
          r_d = '0;
          if (state_q == S_DIR && allow_inv_q) begin
            state_d = S_INV;
          end else begin
            found_d    = 1'b0;
            inverted_d = 1'b0;
            imm8_d     = 8'd0;
            rotate_d   = '0;
            state_d    = S_DONE;
          end
        end else begin
          r_d = r_q + ROT_W'(1);
        end
      end
      S_DONE: begin
        if (enc_if.result_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      value_q     <= 32'd0;
      allow_inv_q <= 1'b0;
      r_q         <= '0;
      found_q     <= 1'b0;
      inverted_q  <= 1'b0;
      imm8_q      <= 8'd0;
      rotate_q    <= '0;
    end else begin
      state_q     <= state_d;
      value_q     <= value_d;
      allow_inv_q <= allow_inv_d;
      r_q         <= r_d;
      found_q     <= found_d;
      inverted_q  <= inverted_d;
      imm8_q      <= imm8_d;
      rotate_q    <= rotate_d;
    end
  end

  assign enc_if.start_ready     = (state_q == S_IDLE);
  assign enc_if.result_valid    = (state_q == S_DONE);
  assign enc_if.result_found    = found_q;
  assign enc_if.result_inverted = inverted_q;
  assign enc_if.result_imm8     = imm8_q;
  assign enc_if.result_rotate   = rotate_q;

endmodule
`default_nettype wire

// File: tb/tb_imm32_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_imm32_encoder : directed + random checks of imm32_encoder against a
// brute-force imm8/rotate enumeration model. Revision: 1.0
// ---------------------------------------------------------------------------
module tb_imm32_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  imm32_encoder_if #(.ROT_W(4)) bus_if ();

  imm32_encoder #(.ROT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .enc_if (bus_if)
  );

  function automatic logic [31:0] ror32(input logic [31:0] x, input int s);
    if (s == 0) return x;
    return (x >> s) | (x << (32 - s));
  endfunction

  // Enumerate every (rotate, imm8) pair; the first match in rotate order wins.
  task automatic model(input logic [31:0] v, input logic inv_ok,
                       output logic f, output logic iv, output logic [7:0] im,
                       output logic [3:0] ro, output int lat);
    logic [31:0] tgt;
    f = 1'b0; iv = 1'b0; im = 8'd0; ro = 4'd0;
    lat = inv_ok ? 32 : 16;
    for (int pass = 0; pass < (inv_ok ? 2 : 1); pass++) begin
      tgt = (pass == 1) ? ~v : v;
      for (int r = 0; r < 16; r++) begin
        for (int i = 0; i < 256; i++) begin
          if (!f && ror32(32'(i), 2 * r) == tgt) begin
            f   = 1'b1;
            iv  = (pass == 1);
            im  = 8'(i);
            ro  = 4'(r);
            lat = pass * 16 + r + 1;
          end
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from a negedge; returns at the negedge where result_valid is seen.
  task automatic request(input logic [31:0] v, input logic inv, output int lat);
    @(negedge clk);
    chk("start_ready_idle", 32'(bus_if.start_ready), 32'd1);
    bus_if.start_valid     = 1'b1;
    bus_if.start_value     = v;
    bus_if.start_allow_inv = inv;
    @(posedge clk);
    @(negedge clk);
    bus_if.start_valid = 1'b0;
    lat = 0;
    while (bus_if.result_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input logic [31:0] v, input logic inv, input int lat);
    logic f, iv;
    logic [7:0] im;
    logic [3:0] ro;
    int el;
    logic [31:0] recon;
    model(v, inv, f, iv, im, ro, el);
    chk("latency",  32'(lat), 32'(el));
    chk("found",    32'(bus_if.result_found), 32'(f));
    chk("inverted", 32'(bus_if.result_inverted), 32'(iv));
    chk("imm8",     32'(bus_if.result_imm8), 32'(im));
    chk("rotate",   32'(bus_if.result_rotate), 32'(ro));
    if (bus_if.result_found === 1'b1) begin
      recon = ror32({24'd0, bus_if.result_imm8}, 2 * int'(bus_if.result_rotate));
      if (bus_if.result_inverted === 1'b1) recon = ~recon;
      chk("reconstruct", recon, v);
    end
  endtask

  // Called at a negedge while result_valid is high.
  task automatic accept();
    bus_if.result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.result_ready = 1'b0;
    chk("post_accept_ready", 32'(bus_if.start_ready), 32'd1);
    chk("post_accept_valid", 32'(bus_if.result_valid), 32'd0);
  endtask

  task automatic do_case(input logic [31:0] v, input logic inv);
    int lat;
    request(v, inv, lat);
    check_result(v, inv, lat);
    accept();
  endtask

  initial begin
    int lat;
    logic [31:0] v, base;
    logic [7:0]  im;
    int          r, kind;

    bus_if.start_valid     = 1'b0;
    bus_if.start_value     = 32'd0;
    bus_if.start_allow_inv = 1'b0;
    bus_if.result_ready    = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_start_ready", 32'(bus_if.start_ready), 32'd1);
    chk("rst_valid",       32'(bus_if.result_valid), 32'd0);
    chk("rst_found",       32'(bus_if.result_found), 32'd0);
    chk("rst_inverted",    32'(bus_if.result_inverted), 32'd0);
    chk("rst_imm8",        32'(bus_if.result_imm8), 32'd0);
    chk("rst_rotate",      32'(bus_if.result_rotate), 32'd0);

    do_case(32'h0000_00FF, 1'b0);
    do_case(32'hFF00_0000, 1'b0);

    // Result held under backpressure while a stray start is ignored.
    request(32'hF000_000F, 1'b0, lat);
    check_result(32'hF000_000F, 1'b0, lat);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus_if.start_valid = 1'b1;
        bus_if.start_value = 32'h1234_5678;
      end
      @(posedge clk);
      @(negedge clk);
      bus_if.start_valid = 1'b0;
      chk("hold_valid",  32'(bus_if.result_valid), 32'd1);
      chk("hold_ready",  32'(bus_if.start_ready), 32'd0);
      chk("hold_found",  32'(bus_if.result_found), 32'd1);
      chk("hold_imm8",   32'(bus_if.result_imm8), 32'hFF);
      chk("hold_rotate", 32'(bus_if.result_rotate), 32'd2);
    end
    accept();
    @(posedge clk);
    @(negedge clk);
    chk("no_queued_start", 32'(bus_if.result_valid), 32'd0);

    do_case(32'hFFFF_FF00, 1'b1);
    do_case(32'hFFFF_FF00, 1'b0);
    do_case(32'h0000_0101, 1'b1);

    // Reset mid-search discards the request.
    @(negedge clk);
    bus_if.start_valid     = 1'b1;
    bus_if.start_value     = 32'h0000_0101;
    bus_if.start_allow_inv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_if.start_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 32'(bus_if.start_ready), 32'd1);
    chk("midrst_valid", 32'(bus_if.result_valid), 32'd0);
    do_case(32'h0000_0000, 1'b0);

    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 3));
      im   = 8'($urandom);
      r    = int'($urandom_range(0, 15));
      base = ror32({24'd0, im}, 2 * r);
      case (kind)
        0:       v = base;
        1:       v = ~base;
        2:       v = $urandom;
        default: v = base ^ (32'd1 << $urandom_range(0, 31));
      endcase
      do_case(v, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
